// File: rtl/piscaleds_n_if.sv
// piscaleds_n_if: switch/LED bundle between the board top level and the LED pattern generator.
interface piscaleds_n_if #(parameter int N_CH = 4);
    logic [N_CH+3:0] SW;
    logic [N_CH-1:0] LEDR;
    modport master (output SW, input LEDR);
    modport slave (input SW, output LEDR);
endinterface

// File: rtl/piscaleds_n.sv
// piscaleds_n: N-channel LED pattern generator driven by a fractional-step prescaler tick.
// SW = {mode[1:0], sel[1:0], en[N_CH-1:0]}; LEDR is registered, one cycle behind state.
module piscaleds_n #(
    parameter int N_CH        = 4,
    parameter int HALF_PERIOD = 50000000,
    parameter int CNT_W       = 27
) (
    input  logic         CLOCK_50,
    input  logic [0:0]   KEY,
    piscaleds_n_if.slave bus
);
    localparam int PW = $clog2(N_CH);
    typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             phase;
    logic [PW-1:0]    pos;
    dir_t             dir;
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  pat;
    logic [1:0]       sel;
    logic [1:0]       mode;
    logic [CNT_W:0]   step;
    logic [CNT_W:0]   sum;
    logic             wrap;
    logic             last;
    logic [PW-1:0]    pos_nxt;
    dir_t             dir_nxt;
    always_comb begin
        en   = bus.SW[N_CH-1:0];
        sel  = bus.SW[N_CH+1:N_CH];
        mode = bus.SW[N_CH+3:N_CH+2];
        step = (CNT_W+1)'(1) << sel;
        sum  = {1'b0, cnt} + step;
        // >= rather than == so a large step can never jump over the wrap point
        wrap = sum >= (CNT_W+1)'(HALF_PERIOD);
        last = pos == PW'(N_CH - 1);
        for (int i = 0; i < N_CH; i++)
            pat[i] = mode[1] ? (pos == PW'(i)) : (phase ^ (mode[0] & i[0]));
        pos_nxt = !mode[0] ? (last ? '0 : pos + 1'b1) :
                  dir == UP ? (last ? PW'(N_CH - 2) : pos + 1'b1) :
                  (pos == '0 ? PW'(1) : pos - 1'b1);
        dir_nxt = !mode[0] ? dir :
                  dir == UP ? (last ? DOWN : UP) :
                  (pos == '0 ? UP : DOWN);
    end
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            cnt      <= '0;
            tick     <= 1'b0;
            phase    <= 1'b0;
            pos      <= '0;
            dir      <= UP;
            bus.LEDR <= '0;
        end else begin
            cnt      <= wrap ? CNT_W'(sum - (CNT_W+1)'(HALF_PERIOD)) : sum[CNT_W-1:0];
            tick     <= wrap;
            phase    <= phase ^ wrap;
            if (wrap && mode[1]) begin
                pos <= pos_nxt;
                dir <= dir_nxt;
            end
            bus.LEDR <= pat & en;
        end
    end
endmodule

// File: tb/tb_piscaleds_n.sv
// tb_piscaleds_n: scoreboard bench; a behavioural model queues expected {LEDR,cnt,tick} per edge.
module tb_piscaleds_n;
    localparam int NCH = 4;
    localparam int HP  = 10;
    typedef struct packed {
        logic [3:0] led;
        logic [4:0] cnt;
        logic       tick;
    } exp_t;
    logic       CLOCK_50 = 0;
    logic [0:0] KEY = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    exp_t e, a;
    int m_cnt = 0;
    int m_pos = 0;
    bit m_phase = 0;
    bit m_up = 1;
    piscaleds_n_if #(.N_CH(NCH)) bus ();
    piscaleds_n #(.N_CH(NCH), .HALF_PERIOD(HP), .CNT_W(5)) dut (
        .CLOCK_50(CLOCK_50),
        .KEY(KEY),
        .bus(bus.slave)
    );
    always #5 CLOCK_50 = ~CLOCK_50;
    task automatic drive(input logic k, input logic [7:0] s);
        int c;
        int md;
        bit t;
        logic [3:0] p;
        logic [3:0] led;
        @(negedge CLOCK_50);
        KEY = k;
        bus.SW = s;
        md = int'(s[7:6]);
        if (!k) begin
            m_cnt = 0; m_phase = 0; m_pos = 0; m_up = 1; t = 0; led = 0;
        end else begin
            c = m_cnt + (1 << s[5:4]);
            t = c >= HP;
            if (t) c -= HP;
            for (int i = 0; i < NCH; i++)
                p[i] = md >= 2 ? (i == m_pos) : (m_phase ^ (md == 1 && i % 2 == 1));
            led = p & s[3:0];
            if (t) begin
                m_phase = !m_phase;
                if (md == 2) m_pos = (m_pos + 1) % NCH;
                else if (md == 3) begin
                    if (m_up) begin
                        if (m_pos == NCH - 1) begin m_up = 0; m_pos = NCH - 2; end
                        else m_pos++;
                    end else begin
                        if (m_pos == 0) begin m_up = 1; m_pos = 1; end
                        else m_pos--;
                    end
                end
            end
            m_cnt = c;
        end
        q.push_back({led, 5'(m_cnt), t});
        @(posedge CLOCK_50);
        #1;
    endtask
    task automatic test_reset;
        int n;
        for (int i = 0; i < 24; i++) begin
            drive(i < 3 ? 1'b0 : 1'b1, 8'b00_00_1111);
            n = i - 2;
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL reset_blink edge %0d: got %h want %h", i, a, e); end
            if (i < 3) begin
                vectors++;
                if (bus.LEDR !== 4'b0000) begin miscompares++; $display("FAIL reset_led: got %b want 0000", bus.LEDR); end
            end
            if (n == 9 || n == 10) begin
                vectors++;
                if (dut.tick !== (n == 10)) begin miscompares++; $display("FAIL first_tick edge %0d: got %b want %b", n, dut.tick, n == 10); end
            end
            if (n == 11 || n == 21) begin
                vectors++;
                if (bus.LEDR !== (n == 11 ? 4'b1111 : 4'b0000)) begin miscompares++; $display("FAIL blink edge %0d: got %b", n, bus.LEDR); end
            end
        end
    endtask
    task automatic test_fractional;
        int cseq[6] = '{8, 6, 4, 2, 0, 8};
        bit tseq[7] = '{0, 1, 1, 1, 1, 0, 1};
        int ticks = 0;
        for (int i = 0; i <= 50; i++) begin
            drive(i != 0, 8'b00_11_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL fractional edge %0d: got %h want %h", i, a, e); end
            if (i >= 1) ticks += int'(dut.tick);
            if (i >= 1 && i <= 6) begin
                vectors++;
                if (int'(dut.cnt) != cseq[i-1]) begin miscompares++; $display("FAIL frac_cnt edge %0d: got %0d want %0d", i, dut.cnt, cseq[i-1]); end
            end
            if (i >= 1 && i <= 7) begin
                vectors++;
                if (dut.tick !== tseq[i-1]) begin miscompares++; $display("FAIL frac_tick edge %0d: got %b want %b", i, dut.tick, tseq[i-1]); end
            end
        end
        vectors++;
        if (ticks != 40) begin miscompares++; $display("FAIL tick_count: got %0d want 40", ticks); end
    endtask
    task automatic test_speed_change;
        for (int i = 0; i <= 8; i++) begin
            drive(i != 0, i <= 5 ? 8'b00_00_1111 : 8'b00_10_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL speed_change edge %0d: got %h want %h", i, a, e); end
            if (i == 7) begin
                vectors++;
                if ({dut.tick, dut.cnt} !== {1'b1, 5'd3}) begin miscompares++; $display("FAIL speed_keep_cnt: got tick %b cnt %0d want 1 3", dut.tick, dut.cnt); end
            end
        end
    endtask
    task automatic test_alternate;
        for (int i = 0; i <= 25; i++) begin
            drive(i != 0, 8'b01_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL alternate edge %0d: got %h want %h", i, a, e); end
            if (i == 1 || i == 11 || i == 21) begin
                vectors++;
                if (bus.LEDR !== (i == 11 ? 4'b0101 : 4'b1010)) begin miscompares++; $display("FAIL alt_led edge %0d: got %b", i, bus.LEDR); end
            end
        end
    endtask
    task automatic test_chase;
        logic [3:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i <= 41; i++) begin
            drive(i != 0, 8'b10_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL chase edge %0d: got %h want %h", i, a, e); end
            if (i % 10 == 1) begin
                vectors++;
                if (bus.LEDR !== want[i/10]) begin miscompares++; $display("FAIL chase_led edge %0d: got %b want %b", i, bus.LEDR, want[i/10]); end
            end
        end
    endtask
    task automatic test_bounce;
        logic [3:0] want[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        for (int i = 0; i <= 71; i++) begin
            drive(i != 0, 8'b11_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL bounce edge %0d: got %h want %h", i, a, e); end
            if (i % 10 == 1) begin
                vectors++;
                if (bus.LEDR !== want[i/10]) begin miscompares++; $display("FAIL bounce_led edge %0d: got %b want %b", i, bus.LEDR, want[i/10]); end
            end
        end
    endtask
    task automatic test_mask_switch;
        for (int i = 0; i <= 31; i++) begin
            drive(i != 0, 8'b10_00_1101);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL mask edge %0d: got %h want %h", i, a, e); end
            if (i == 11 || i == 21) begin
                vectors++;
                if ({bus.LEDR, 2'(dut.pos)} !== (i == 11 ? {4'b0000, 2'd1} : {4'b0100, 2'd2})) begin
                    miscompares++; $display("FAIL mask_pos edge %0d: got led %b pos %0d", i, bus.LEDR, dut.pos);
                end
            end
        end
        for (int i = 0; i <= 41; i++) begin
            drive(i != 0, 8'b11_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL pre_switch edge %0d: got %h want %h", i, a, e); end
        end
        vectors++;
        if ({2'(dut.pos), 1'(dut.dir)} !== {2'd2, 1'b0}) begin miscompares++; $display("FAIL pre_switch_state: got pos %0d dir %b want 2 0", dut.pos, dut.dir); end
        for (int j = 1; j <= 20; j++) begin
            drive(1'b1, 8'b10_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL live_switch step %0d: got %h want %h", j, a, e); end
            if (j == 10 || j == 20) begin
                vectors++;
                if (bus.LEDR !== (j == 10 ? 4'b1000 : 4'b0001)) begin miscompares++; $display("FAIL switch_led step %0d: got %b", j, bus.LEDR); end
            end
        end
    endtask
    task automatic test_mid_reset;
        for (int i = 0; i <= 37; i++) begin
            drive(i != 0, 8'b10_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL mid_run edge %0d: got %h want %h", i, a, e); end
        end
        vectors++;
        if ({2'(dut.pos), dut.cnt} !== {2'd3, 5'd7}) begin miscompares++; $display("FAIL mid_pre: got pos %0d cnt %0d want 3 7", dut.pos, dut.cnt); end
        for (int j = 0; j <= 10; j++) begin
            drive(j != 0, 8'b10_00_1111);
            e = q.pop_front(); a = {bus.LEDR, dut.cnt, dut.tick}; vectors++;
            if (a !== e) begin miscompares++; $display("FAIL mid_reset step %0d: got %h want %h", j, a, e); end
            if (j == 0) begin
                vectors++;
                if ({bus.LEDR, dut.cnt} !== 9'd0) begin miscompares++; $display("FAIL mid_clear: got led %b cnt %0d want 0000 0", bus.LEDR, dut.cnt); end
            end
            if (j == 1) begin
                vectors++;
                if (bus.LEDR !== 4'b0001) begin miscompares++; $display("FAIL mid_release: got %b want 0001", bus.LEDR); end
            end
            if (j == 9 || j == 10) begin
                vectors++;
                if (dut.tick !== (j == 10)) begin miscompares++; $display("FAIL mid_tick step %0d: got %b want %b", j, dut.tick, j == 10); end
            end
        end
    endtask
    initial begin
        bus.SW = 8'b00_00_1111;
        test_reset;
        test_fractional;
        test_speed_change;
        test_alternate;
        test_chase;
        test_bounce;
        test_mask_switch;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
